// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite encodings and the responder state type used by the
// AHB-Lite slave blocks.
package ahblite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } slave_state_e;

endpackage

// File: rtl/ahblite_slave_bytemask.sv
// Byte-lane decode for a 32-bit AHB-Lite data bus: transfer size and the low
// address bits select the active lanes and flag misaligned accesses.
module ahblite_slave_bytemask
    import ahblite_pkg::*;
(
    input  logic [2:0] hsize_i,
    input  logic [1:0] addr_i,
    output logic [3:0] mask_o,
    output logic       misaligned_o
);

    // Lane mask and alignment check; oversize transfers enable no lanes.
    always_comb begin
        mask_o       = 4'b0000;
        misaligned_o = 1'b0;
        case (hsize_i)
            HSIZE_BYTE: begin
                mask_o = 4'b0001 << addr_i;
            end
            HSIZE_HALF: begin
                mask_o       = addr_i[1] ? 4'b1100 : 4'b0011;
                misaligned_o = addr_i[0];
            end
            HSIZE_WORD: begin
                mask_o       = 4'b1111;
                misaligned_o = (addr_i != 2'b00);
            end
            default: begin
                mask_o       = 4'b0000;
                misaligned_o = (addr_i != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/ahblite_slave_regfile.sv
// AHB-Lite responder exposing a bank of read/write registers with
// programmable wait states and the two-cycle ERROR response.
module ahblite_slave_regfile
    import ahblite_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hready,
    output logic [DATA_WIDTH-1:0] hrdata_o,
    output logic                  hreadyout_o,
    output logic                  hresp_o
);

    localparam int         IDX_W     = $clog2(NUM_REGS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    slave_state_e          state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  hwrite_q, hwrite_d;
    logic [3:0]            mask_q, mask_d;
    logic                  hreadyout_q, hreadyout_d;
    logic                  hresp_q, hresp_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    logic       addr_valid_s;
    logic       range_err_s;
    logic       misaligned_s;
    logic       err_s;
    logic [3:0] lane_mask_s;
    logic       commit_s;
    logic       read_s;

    ahblite_slave_bytemask u_bytemask (
        .hsize_i      (hsize),
        .addr_i       (haddr[1:0]),
        .mask_o       (lane_mask_s),
        .misaligned_o (misaligned_s)
    );

    assign addr_valid_s = hsel && hready &&
                          ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
    assign range_err_s  = (haddr[ADDR_WIDTH-1:IDX_W+2] != '0);
    assign err_s        = range_err_s || (hsize > HSIZE_WORD) || misaligned_s;

    // The data phase completes on the cycle the registered ready is high.
    assign commit_s = (state_q == ST_DATA) && (cnt_q == 4'd0) && hwrite_q;
    assign read_s   = (state_q == ST_DATA) && (cnt_q == 4'd0) && !hwrite_q;

    // Next-state, address-phase capture and registered response decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        hwrite_d = hwrite_q;
        mask_d   = mask_q;
        if (hreadyout_q) begin
            if (addr_valid_s) begin
                idx_d    = haddr[IDX_W+1:2];
                hwrite_d = hwrite;
                mask_d   = lane_mask_s;
                if (err_s) begin
                    state_d = ST_ERR1;
                    cnt_d   = 4'd0;
                end else begin
                    state_d = ST_DATA;
                    cnt_d   = WAIT_INIT;
                end
            end else begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        end else begin
            case (state_q)
                ST_DATA: cnt_d   = cnt_q - 4'd1;
                ST_ERR1: state_d = ST_ERR2;
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
        hreadyout_d = (state_d == ST_DATA) ? (cnt_d == 4'd0) : (state_d != ST_ERR1);
        hresp_d     = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    end

    // Control and response registers.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            idx_q       <= '0;
            hwrite_q    <= 1'b0;
            mask_q      <= 4'b0000;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            hwrite_q    <= hwrite_d;
            mask_q      <= mask_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    // Register bank; hwdata is sampled on the completing edge of a write.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit_s) begin
            for (int b = 0; b < 4; b++) begin
                if (mask_q[b]) begin
                    regs_q[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
                end
            end
        end
    end

    // Read mux: the full word is driven only while a read completes.
    always_comb begin
        if (read_s) begin
            hrdata_o = regs_q[idx_q];
        end else begin
            hrdata_o = '0;
        end
    end

    assign hreadyout_o = hreadyout_q;
    assign hresp_o     = hresp_q;

endmodule

// File: tb/tb_ahblite_slave_regfile.sv
// Self-checking bench for ahblite_slave_regfile: directed test-plan steps plus
// randomized transfers scored against a word-array reference model.
module tb_ahblite_slave_regfile;

    localparam int NREGS = 16;

    logic        hclk = 1'b0;
    logic        hreset, hsel, hsel0, hwrite, hready;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [31:0] hrdata, hrdata0;
    logic        hreadyout, hreadyout0, hresp, hresp0;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] mem [NREGS];

    always #5 hclk = ~hclk;

    ahblite_slave_regfile #(.WAIT_STATES(1)) dut (
        .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
        .hrdata_o(hrdata), .hreadyout_o(hreadyout), .hresp_o(hresp)
    );

    ahblite_slave_regfile #(.WAIT_STATES(0)) dut0 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
        .hrdata_o(hrdata0), .hreadyout_o(hreadyout0), .hresp_o(hresp0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_err(input logic [31:0] a, input logic [2:0] sz);
        if (sz > 3'd2) return 1'b1;
        if (a >= 32'(NREGS * 4)) return 1'b1;
        if ((a % (32'd1 << sz)) != 32'd0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
        int off = int'(a % 32'd4);
        int n   = 1 << sz;
        for (int b = 0; b < 4; b++) begin
            if (b >= off && b < off + n) mem[a / 32'd4][8*b +: 8] = wd[8*b +: 8];
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NREGS; i++) mem[i] = 32'd0;
    endtask

    // One non-pipelined transfer on the WAIT_STATES=1 instance.
    task automatic xfer(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic resp1, output logic resp_end, output int waits);
        hsel = 1'b1; haddr = a; htrans = 2'd2; hwrite = wr; hsize = sz;
        @(posedge hclk); #1;
        htrans = 2'd0; hwdata = wd;
        waits = 0;
        @(negedge hclk);
        resp1 = hresp;
        while (!hreadyout && waits < 20) begin
            waits++;
            @(negedge hclk);
        end
        rd = hrdata; resp_end = hresp;
        @(posedge hclk); #1;
        hsel = 1'b0;
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic wr,
                       input logic [2:0] sz, input logic [31:0] wd, output logic [31:0] rd);
        logic        r1, re;
        int          w;
        bit          err = model_err(a, sz);
        logic [31:0] exp_rd = (wr || err) ? 32'd0 : mem[a / 32'd4];
        xfer(a, wr, sz, wd, rd, r1, re, w);
        check({tag, " resp_first"}, {31'd0, r1}, {31'd0, err});
        check({tag, " wait_cycles"}, 32'(w), 32'd1);
        check({tag, " resp_last"}, {31'd0, re}, {31'd0, err});
        check({tag, " rdata"}, rd, exp_rd);
        if (wr && !err) model_write(a, sz, wd);
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  nt_trans [3];
        logic        nt_sel   [3];
        hreset = 1'b1; hsel = 1'b0; hsel0 = 1'b0; haddr = 32'd0; htrans = 2'd0;
        hwrite = 1'b0; hsize = 3'd0; hwdata = 32'd0; hready = 1'b1;
        clear_model();
        repeat (2) @(posedge hclk);
        #1 hreset = 1'b0;
        @(negedge hclk);
        check("reset hreadyout", {31'd0, hreadyout}, 32'd1);
        check("reset hresp", {31'd0, hresp}, 32'd0);
        check("reset hrdata", hrdata, 32'd0);
        check("reset hreadyout ws0", {31'd0, hreadyout0}, 32'd1);

        run("w08", 32'h08, 1'b1, 3'd2, 32'hDEADBEEF, rd);
        run("r08", 32'h08, 1'b0, 3'd2, 32'd0, rd);
        check("r08 value", rd, 32'hDEADBEEF);
        run("wb0D", 32'h0D, 1'b1, 3'd0, 32'hAAAAAAAA, rd);
        run("r0C a", 32'h0C, 1'b0, 3'd2, 32'd0, rd);
        check("byte lane value", rd, 32'h0000AA00);
        run("wh0E", 32'h0E, 1'b1, 3'd1, 32'h12341234, rd);
        run("r0C b", 32'h0C, 1'b0, 3'd2, 32'd0, rd);
        check("half lane value", rd, 32'h1234AA00);

        run("err range", 32'h40, 1'b1, 3'd2, 32'hFFFFFFFF, rd);
        run("err size", 32'h00, 1'b1, 3'd3, 32'hFFFFFFFF, rd);
        run("err misalign", 32'h01, 1'b1, 3'd1, 32'hFFFFFFFF, rd);
        run("post err r00", 32'h00, 1'b0, 3'd2, 32'd0, rd);
        check("post err r00 value", rd, 32'd0);
        run("post err r0C", 32'h0C, 1'b0, 3'd2, 32'd0, rd);
        check("post err r0C value", rd, 32'h1234AA00);

        nt_trans = '{2'd0, 2'd1, 2'd2};
        nt_sel   = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            hsel = nt_sel[i]; htrans = nt_trans[i]; hwrite = 1'b1;
            haddr = 32'h08; hsize = 3'd2; hwdata = 32'h0BADF00D;
            @(posedge hclk); #1;
            htrans = 2'd0; hsel = 1'b0;
            @(negedge hclk);
            check($sformatf("no-xfer %0d hreadyout", i), {31'd0, hreadyout}, 32'd1);
            check($sformatf("no-xfer %0d hresp", i), {31'd0, hresp}, 32'd0);
        end
        @(posedge hclk); #1;
        run("no-xfer r08", 32'h08, 1'b0, 3'd2, 32'd0, rd);
        check("no-xfer r08 value", rd, 32'hDEADBEEF);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a  = 32'($urandom_range(0, 79));
            int          r  = $urandom_range(0, 9);
            logic [2:0]  sz = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'($urandom_range(3, 7));
            logic        wr = 1'($urandom_range(0, 1));
            if (r < 9 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            run($sformatf("rnd%0d", n), a, wr, sz, $urandom, rd);
        end

        hsel = 1'b1; haddr = 32'h00; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2;
        @(posedge hclk); #1;
        hreset = 1'b1; htrans = 2'd0; hsel = 1'b0; hwdata = 32'hFFFFFFFF;
        @(posedge hclk); #1;
        hreset = 1'b0;
        clear_model();
        @(negedge hclk);
        check("mid-reset hreadyout", {31'd0, hreadyout}, 32'd1);
        check("mid-reset hresp", {31'd0, hresp}, 32'd0);
        @(posedge hclk); #1;
        run("mid-reset r00", 32'h00, 1'b0, 3'd2, 32'd0, rd);
        check("mid-reset r00 value", rd, 32'd0);

        hsel0 = 1'b1; haddr = 32'h04; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2;
        @(posedge hclk); #1;
        hwrite = 1'b0; hwdata = 32'h5;
        @(negedge hclk);
        check("ws0 write hreadyout", {31'd0, hreadyout0}, 32'd1);
        @(posedge hclk); #1;
        htrans = 2'd0; hsel0 = 1'b0;
        @(negedge hclk);
        check("ws0 read hreadyout", {31'd0, hreadyout0}, 32'd1);
        check("ws0 read hresp", {31'd0, hresp0}, 32'd0);
        check("ws0 read value", hrdata0, 32'h5);
        @(posedge hclk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
